// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency load/store with byte-lane steering, load extension and legality checks.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (flags accesses at or beyond 4*MEM_DEPTH bytes as illegal).
module dmem_responder #(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_be,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and response outputs stay stable while resp_valid waits.

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        lat_write;
    logic        lat_unsigned;
    logic [3:0]  lat_be;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [MEM_DEPTH];

    logic          accept;
    logic          do_access;
    logic          legal;
    logic [1:0]    offset;
    logic [AW-1:0] idx;
    logic [3:0]    lane_mask;
    logic [31:0]   wdata_sh;
    logic [31:0]   rd_sh;
    logic [31:0]   load_data;

    assign accept    = req_valid && req_ready;
    assign do_access = (state_q == WAIT) && (cnt_q == 4'd0);
    assign offset    = lat_addr[1:0];
    assign idx       = lat_addr[2 +: AW];
    assign lane_mask = lat_be << offset;
    assign wdata_sh  = lat_wdata << {offset, 3'b000};
    assign rd_sh     = mem[idx] >> {offset, 3'b000};

    always_comb begin
        legal = 1'b0;
        case (lat_be)
            4'b0001: legal = 1'b1;
            4'b0011: legal = ~lat_addr[0];
            4'b1111: legal = (lat_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
`ifdef DMEM_BOUNDS_CHECK_EN
        if ((lat_addr >> (AW + 2)) != 32'd0) legal = 1'b0;
`endif
    end

    always_comb begin
        load_data = rd_sh;
        case (lat_be)
            4'b0001: load_data = lat_unsigned ? {24'd0, rd_sh[7:0]}
                                              : {{24{rd_sh[7]}}, rd_sh[7:0]};
            4'b0011: load_data = lat_unsigned ? {16'd0, rd_sh[15:0]}
                                              : {{16{rd_sh[15]}}, rd_sh[15:0]};
            default: load_data = rd_sh;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_be       <= 4'd0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lat_write    <= req_write;
                lat_unsigned <= req_unsigned;
                lat_be       <= req_be;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                cnt_q        <= 4'(LATENCY - 1);
            end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (do_access) begin
                rdata_q <= (legal && !lat_write) ? load_data : 32'd0;
                err_q   <= ~legal;
            end
        end
    end

    // Storage is not reset; a reset in the access cycle suppresses the write.
    always_ff @(posedge CLK) begin
        if (!RST && do_access && lat_write && legal) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state_q;

endmodule
